// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the N-port Wishbone arbiter.
//   arb_mode_e  : round-robin or fixed-priority selection
//   arb_state_e : arbiter ownership FSM states
//   STAT_*_OFS  : word offsets of the per-port counters in the stats map
package wb_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int STAT_GRANT_OFS = 0;
  localparam int STAT_WAIT_OFS  = 1;
  localparam int MAX_PORTS      = 8;

endpackage

// File: rtl/if_wb.sv
// Wishbone classic bus bundle.
//   master modport : drives cyc/stb/we/sel/adr/dat_m, receives dat_s/ack
//   slave modport  : receives cyc/stb/we/sel/adr/dat_m, drives dat_s/ack
interface if_wb #(
  parameter int AW = 26,
  parameter int DW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_m;
  logic [DW-1:0] dat_s;
  logic          ack;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack);

endinterface

// File: rtl/wb_arbiter_n_arb_pick.sv
// Combinational winner picker.
//   req_i     : request vector (one bit per port)
//   last_i    : index of the most recent grant (round-robin pointer)
//   mode_i    : ARB_RR searches from last_i+1 upward with wrap,
//               ARB_FIXED takes the lowest requesting index
//   win_oh_o  : one-hot winner, 0 when nothing requests
//   win_idx_o : winner index
//   any_o     : at least one request present
module arb_pick
  import wb_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IW     = 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     last_i,
  input  arb_mode_e         mode_i,
  output logic [NPORTS-1:0] win_oh_o,
  output logic [IW-1:0]     win_idx_o,
  output logic              any_o
);

  always_comb begin
    int idx;
    idx       = 0;
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    // Scan candidates in priority order; the first hit wins.
    for (int k = 0; k < NPORTS; k++) begin
      idx = (mode_i == ARB_FIXED) ? k : (int'(last_i) + 1 + k) % NPORTS;
      if (!any_o && req_i[idx[IW-1:0]]) begin
        any_o                 = 1'b1;
        win_idx_o             = idx[IW-1:0];
        win_oh_o[idx[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-port Wishbone arbiter in front of the SDRAM controller / cache.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus[NPORTS]  : upstream masters (slave side of each)
//   out          : downstream master port
//   stats        : statistics slave; word 2i = grant_cnt[i], 2i+1 = wait_cnt[i],
//                  any write clears every counter
//   grant_o      : one-hot current owner, 0 when idle
//   busy_o       : some port owns the downstream bus
module wb_arbiter_n
  import wb_arb_pkg::*;
#(
  parameter int NPORTS    = 2,
  parameter int AWIDTH    = 26,
  parameter int DWIDTH    = 32,
  parameter int ARB_MODE  = 0,
  parameter int CNT_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.slave               bus [NPORTS],
  if_wb.master              out,
  if_wb.slave               stats,
  output logic [NPORTS-1:0] grant_o,
  output logic              busy_o
);

  localparam int        IW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;

  // Flattened view of the upstream requests so they can be indexed by owner_q.
  logic [NPORTS-1:0]                 req_cyc, req_stb, req_we;
  logic [NPORTS-1:0][DWIDTH/8-1:0]   req_sel;
  logic [NPORTS-1:0][AWIDTH-1:0]     req_adr;
  logic [NPORTS-1:0][DWIDTH-1:0]     req_dat;

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic              owned;
  logic              grant_evt;

  logic [NPORTS-1:0] pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  assign owned = (state_q == OWNED);

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign req_cyc[g]   = bus[g].cyc;
    assign req_stb[g]   = bus[g].stb;
    assign req_we[g]    = bus[g].we;
    assign req_sel[g]   = bus[g].sel;
    assign req_adr[g]   = bus[g].adr;
    assign req_dat[g]   = bus[g].dat_m;
    assign bus[g].ack   = owned & (owner_q == IW'(g)) & out.ack;
    assign bus[g].dat_s = out.dat_s;
  end

  arb_pick #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_pick (
    .req_i     (req_cyc),
    .last_i    (last_q),
    .mode_i    (MODE),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Ownership FSM. A grant is only made from IDLE, which gives the one dead
  // cycle between owners and keeps bursts/RMW sequences unsplit.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = OWNED;
          owner_d   = pick_idx;
          last_d    = pick_idx;
          grant_evt = 1'b1;
        end
      end
      OWNED: begin
        if (!req_cyc[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign out.cyc   = owned & req_cyc[owner_q];
  assign out.stb   = owned & req_stb[owner_q];
  assign out.we    = owned & req_we[owner_q];
  assign out.sel   = req_sel[owner_q];
  assign out.adr   = req_adr[owner_q];
  assign out.dat_m = req_dat[owner_q];

  always_comb begin
    grant_o = '0;
    if (owned) grant_o[owner_q] = 1'b1;
  end
  assign busy_o = owned;

  // ---------------- statistics ----------------
  logic [NPORTS-1:0][CNT_WIDTH-1:0] grant_cnt_q, wait_cnt_q;
  logic              st_seen_q;
  logic              st_ack_q;
  logic [DWIDTH-1:0] st_dat_q;
  logic              st_req, st_clr;
  logic [4:0]        st_word;
  logic [DWIDTH-1:0] st_rdata;
  logic              unused_stats;

  // A new stats access is accepted only if stb was low the previous cycle,
  // so a held stb produces a single ack.
  assign st_req  = stats.cyc & stats.stb & ~st_seen_q;
  assign st_clr  = st_req & stats.we;
  assign st_word = stats.adr[4:0];
  assign unused_stats = ^{stats.sel, stats.dat_m, stats.adr[AWIDTH-1:5]};

  always_ff @(posedge clk_i) begin
    if (rst_i || st_clr) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (grant_evt && pick_oh[i] && grant_cnt_q[i] != '1)
          grant_cnt_q[i] <= grant_cnt_q[i] + CNT_WIDTH'(1);
        if (req_cyc[i] && req_stb[i] && !(owned && owner_q == IW'(i)) &&
            wait_cnt_q[i] != '1)
          wait_cnt_q[i] <= wait_cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    st_rdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (st_word == 5'(2 * i + STAT_GRANT_OFS)) st_rdata = DWIDTH'(grant_cnt_q[i]);
      if (st_word == 5'(2 * i + STAT_WAIT_OFS))  st_rdata = DWIDTH'(wait_cnt_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_seen_q <= 1'b0;
      st_ack_q  <= 1'b0;
      st_dat_q  <= '0;
    end else begin
      st_seen_q <= stats.cyc & stats.stb;
      st_ack_q  <= st_req;
      if (st_req && !stats.we) st_dat_q <= st_rdata;
    end
  end

  assign stats.ack   = st_ack_q;
  assign stats.dat_s = st_dat_q;

endmodule

// File: tb/tb_wb_arbiter_n.sv
module tb_wb_arbiter_n;
  localparam int NP   = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NP-1:0] m_cyc, m_stb, m_we;
  logic [NP-1:0][DW/8-1:0] m_sel;
  logic [NP-1:0][AW-1:0]   m_adr;
  logic [NP-1:0][DW-1:0]   m_dat;
  logic          s_ack;
  logic [DW-1:0] s_dat;
  logic          st_cyc, st_stb, st_we;
  logic [AW-1:0] st_adr;

  logic [NP-1:0] g_rr, g_fx, a_rr, a_fx;
  logic          b_rr, b_fx;

  if_wb #(.AW(AW), .DW(DW)) bus_rr [NP] ();
  if_wb #(.AW(AW), .DW(DW)) bus_fx [NP] ();
  if_wb #(.AW(AW), .DW(DW)) out_rr ();
  if_wb #(.AW(AW), .DW(DW)) out_fx ();
  if_wb #(.AW(AW), .DW(DW)) st_rr ();
  if_wb #(.AW(AW), .DW(DW)) st_fx ();

  for (genvar g = 0; g < NP; g++) begin : g_m
    assign bus_rr[g].cyc = m_cyc[g];  assign bus_fx[g].cyc = m_cyc[g];
    assign bus_rr[g].stb = m_stb[g];  assign bus_fx[g].stb = m_stb[g];
    assign bus_rr[g].we  = m_we[g];   assign bus_fx[g].we  = m_we[g];
    assign bus_rr[g].sel = m_sel[g];  assign bus_fx[g].sel = m_sel[g];
    assign bus_rr[g].adr = m_adr[g];  assign bus_fx[g].adr = m_adr[g];
    assign bus_rr[g].dat_m = m_dat[g]; assign bus_fx[g].dat_m = m_dat[g];
    assign a_rr[g] = bus_rr[g].ack;   assign a_fx[g] = bus_fx[g].ack;
  end
  assign out_rr.ack = s_ack;  assign out_rr.dat_s = s_dat;
  assign out_fx.ack = s_ack;  assign out_fx.dat_s = s_dat;
  assign st_rr.cyc = st_cyc;  assign st_fx.cyc = st_cyc;
  assign st_rr.stb = st_stb;  assign st_fx.stb = st_stb;
  assign st_rr.we  = st_we;   assign st_fx.we  = st_we;
  assign st_rr.adr = st_adr;  assign st_fx.adr = st_adr;
  assign st_rr.sel = '0;      assign st_fx.sel = '0;
  assign st_rr.dat_m = '0;    assign st_fx.dat_m = '0;

  wb_arbiter_n #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .ARB_MODE(0), .CNT_WIDTH(CW)) dut_rr (
    .clk_i(clk), .rst_i(rst), .bus(bus_rr), .out(out_rr), .stats(st_rr),
    .grant_o(g_rr), .busy_o(b_rr));
  wb_arbiter_n #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .ARB_MODE(1), .CNT_WIDTH(CW)) dut_fx (
    .clk_i(clk), .rst_i(rst), .bus(bus_fx), .out(out_fx), .stats(st_fx),
    .grant_o(g_fx), .busy_o(b_fx));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  // own = -1 means nobody owns the bus.
  int own [2];
  int lst [2];
  int gc  [2][NP];
  int wc  [2][NP];
  int sdat[2];
  bit sseen, sack;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic int pick(input int d);
    if (d == 1) begin
      for (int i = 0; i < NP; i++) if (m_cyc[i]) return i;
    end else begin
      for (int k = 1; k <= NP; k++) if (m_cyc[(lst[0] + k) % NP]) return (lst[0] + k) % NP;
    end
    return -1;
  endfunction

  function automatic int rd(input int d, input int a);
    if ((a / 2) >= NP) return 0;
    return (a % 2 == 1) ? wc[d][a / 2] : gc[d][a / 2];
  endfunction

  task automatic model_step();
    bit streq, clr;
    int w;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        own[d] = -1; lst[d] = NP - 1; sdat[d] = 0;
        for (int i = 0; i < NP; i++) begin gc[d][i] = 0; wc[d][i] = 0; end
      end
      sseen = 0; sack = 0;
    end else begin
      streq = st_cyc && st_stb && !sseen;
      clr   = streq && st_we;
      for (int d = 0; d < 2; d++) begin
        if (streq && !st_we) sdat[d] = rd(d, int'(st_adr[4:0]));
        if (clr) begin
          for (int i = 0; i < NP; i++) begin gc[d][i] = 0; wc[d][i] = 0; end
        end else begin
          for (int i = 0; i < NP; i++)
            if (m_cyc[i] && m_stb[i] && own[d] != i) wc[d][i] = sat(wc[d][i]);
        end
        if (own[d] < 0) begin
          if (m_cyc != '0) begin
            w = pick(d);
            own[d] = w; lst[d] = w;
            if (!clr) gc[d][w] = sat(gc[d][w]);
          end
        end else if (!m_cyc[own[d]]) begin
          own[d] = -1;
        end
      end
      sack  = streq;
      sseen = st_cyc && st_stb;
    end
  endtask

  task automatic compare_one(input int d, input string dn, input logic [NP-1:0] g, input logic b,
                             input logic oc, input logic os, input logic ow, input logic [AW-1:0] oa,
                             input logic [NP-1:0] ac, input logic [DW-1:0] ds0, input logic [DW-1:0] ds1,
                             input logic sa, input logic [DW-1:0] sd);
    logic [NP-1:0] eg;
    int o;
    o  = own[d];
    eg = '0;
    if (o >= 0) eg[o] = 1'b1;
    chk({dn, ".grant"}, g, eg);
    chk({dn, ".busy"}, b, o >= 0);
    chk({dn, ".out_cyc"}, oc, (o >= 0) ? m_cyc[o] : 1'b0);
    chk({dn, ".out_stb"}, os, (o >= 0) ? m_stb[o] : 1'b0);
    chk({dn, ".out_we"}, ow, (o >= 0) ? m_we[o] : 1'b0);
    if (o >= 0) chk({dn, ".out_adr"}, oa, m_adr[o]);
    chk({dn, ".acks"}, ac, s_ack ? eg : '0);
    chk({dn, ".dat_s0"}, ds0, s_dat);
    chk({dn, ".dat_sN"}, ds1, s_dat);
    chk({dn, ".st_ack"}, sa, sack);
    chk({dn, ".st_dat"}, sd, DW'(sdat[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_one(0, "rr", g_rr, b_rr, out_rr.cyc, out_rr.stb, out_rr.we, out_rr.adr, a_rr,
                bus_rr[0].dat_s, bus_rr[NP-1].dat_s, st_rr.ack, st_rr.dat_s);
    compare_one(1, "fx", g_fx, b_fx, out_fx.cyc, out_fx.stb, out_fx.we, out_fx.adr, a_fx,
                bus_fx[0].dat_s, bus_fx[NP-1].dat_s, st_fx.ack, st_fx.dat_s);
  endtask

  task automatic st_read(input int a, output int r_rr, output int r_fx);
    st_cyc = 1; st_stb = 1; st_we = 0; st_adr = AW'(a);
    tick();
    chk("st_read.ack", {st_rr.ack, st_fx.ack}, 2'b11);
    r_rr = int'(st_rr.dat_s);
    r_fx = int'(st_fx.dat_s);
    st_cyc = 0; st_stb = 0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; m_cyc = '0; m_stb = '0;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic [NP-1:0] cyc;
    logic [NP-1:0] g_rr;
    logic [NP-1:0] g_fx;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int r0, r1;
    tbl[0]  = '{4'b0010, 4'b0010, 4'b0010};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[3]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[4]  = '{4'b1011, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b1000, 4'b0001};
    tbl[6]  = '{4'b0111, 4'b0000, 4'b0001};
    tbl[7]  = '{4'b1111, 4'b0001, 4'b0001};
    tbl[8]  = '{4'b1110, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[10] = '{4'b1101, 4'b0000, 4'b0001};
    tbl[11] = '{4'b1110, 4'b0100, 4'b0000};

    rst = 1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_ack = 0; s_dat = '0; st_cyc = 0; st_stb = 0; st_we = 0; st_adr = '0;
    tick(); tick();
    chk("reset.grant", {g_rr, g_fx}, '0);
    chk("reset.busy", {b_rr, b_fx}, 2'b00);
    chk("reset.out_cyc", {out_rr.cyc, out_fx.cyc}, 2'b00);
    chk("reset.st_ack", {st_rr.ack, st_fx.ack}, 2'b00);
    chk("reset.st_dat", st_rr.dat_s, '0);
    rst = 0;

    // Single requester, then round-robin rotation vs fixed priority.
    s_ack = 1;
    for (int v = 0; v < 12; v++) begin
      m_cyc = tbl[v].cyc; m_stb = tbl[v].cyc;
      tick();
      chk($sformatf("tbl%0d.g_rr", v), g_rr, tbl[v].g_rr);
      chk($sformatf("tbl%0d.g_fx", v), g_fx, tbl[v].g_fx);
      chk($sformatf("tbl%0d.ack_rr", v), a_rr, tbl[v].g_rr);
    end

    // Fixed priority starves port 2; its wait counter runs.
    do_reset();
    m_cyc = 4'b0101; m_stb = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("fx.only_p0", g_fx, 4'b0001);
    end
    m_cyc = '0; m_stb = '0;
    tick();
    st_read(5, r0, r1); chk("fx.wait2", r1, 10);
    st_read(4, r0, r1); chk("fx.grant2", r1, 0);
    st_read(0, r0, r1); chk("fx.grant0", r1, 1);

    // Burst on port 0 is not split by port 1's request.
    do_reset();
    s_ack = 1; m_cyc = 4'b0011; m_stb = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("burst.g_rr", g_rr, 4'b0001);
      chk("burst.ack", a_rr, 4'b0001);
    end
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick(); chk("burst.dead", g_rr, 4'b0000); chk("burst.dead_ack", a_rr, 4'b0000);
    tick(); chk("burst.p1", g_rr, 4'b0010); chk("burst.p1_ack", a_rr, 4'b0010);
    m_cyc = '0; m_stb = '0;
    tick();
    st_read(0, r0, r1); chk("burst.gcnt0", r0, 1);
    st_read(2, r0, r1); chk("burst.gcnt1", r0, 1);

    // Saturation at all-ones, then clear against a same-cycle grant.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      m_cyc = 4'b0001; m_stb = 4'b0001; tick();
      m_cyc = '0; m_stb = '0; tick();
    end
    st_read(0, r0, r1); chk("sat.gcnt0_rr", r0, MAXC); chk("sat.gcnt0_fx", r1, MAXC);
    m_cyc = 4'b0001; m_stb = 4'b0001; st_cyc = 1; st_stb = 1; st_we = 1;
    tick();
    st_cyc = 0; st_stb = 0; st_we = 0; m_cyc = '0; m_stb = '0;
    tick();
    for (int a = 0; a < 2 * NP; a++) begin
      st_read(a, r0, r1);
      chk($sformatf("clr.w%0d", a), {r0[CW-1:0], r1[CW-1:0]}, '0);
    end
    m_cyc = 4'b0001; m_stb = 4'b0001; tick();
    m_cyc = '0; m_stb = '0; tick();
    st_read(9, r0, r1); chk("range.w9", r0, 0);

    // Reset in the middle of a burst.
    m_cyc = 4'b0011; m_stb = 4'b0011; s_ack = 1;
    tick(); tick(); tick();
    rst = 1;
    tick();
    chk("rstmid.out_cyc", out_rr.cyc, 1'b0);
    chk("rstmid.grant", g_rr, 4'b0000);
    chk("rstmid.ack", a_rr, 4'b0000);
    rst = 0; m_cyc = '0; m_stb = '0;
    tick();
    st_read(0, r0, r1); chk("rstmid.gcnt0", r0, 0);
    st_read(3, r0, r1); chk("rstmid.wcnt1", r0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (m_cyc[i]) begin
          if ($urandom % 4 == 0) m_cyc[i] = 1'b0;
        end else if ($urandom % 3 == 0) m_cyc[i] = 1'b1;
        m_stb[i] = m_cyc[i] & ($urandom % 4 != 0);
        m_we[i]  = 1'($urandom);
        m_adr[i] = AW'($urandom);
        m_dat[i] = DW'($urandom);
        m_sel[i] = 4'($urandom);
      end
      s_ack  = 1'($urandom);
      s_dat  = DW'($urandom);
      st_cyc = ($urandom % 3 == 0);
      st_stb = st_cyc;
      st_we  = st_cyc && ($urandom % 20 == 0);
      st_adr = AW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
